// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-master memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef logic mid_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// Tag FIFO recording which master issued each outstanding read, in issue order.
module mem_arb_tag_fifo
  import mem_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic arst_n_i,
  input  logic push_i,
  input  mid_t push_id_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output mid_t head_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  mid_t          mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count == FULL_CNT);
  assign empty_o = (count == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_id_i;
  end

endmodule

// File: rtl/mem_arb2.sv
// Two-master round-robin arbiter onto one memory slave, routing read responses by tag.
module mem_arb2
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [BE_W-1:0]   m0_be_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic              m0_ack_o,
  output logic              m0_resp_o,
  output logic [DATA_W-1:0] m0_rdata_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [BE_W-1:0]   m1_be_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic              m1_ack_o,
  output logic              m1_resp_o,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [BE_W-1:0]   s_be_o,
  output logic [DATA_W-1:0] s_wdata_o,
  input  logic              s_ack_i,
  input  logic              s_resp_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  output logic              err_o
);

  state_t state, state_nxt;
  mid_t   owner, owner_nxt;
  mid_t   rr;
  mid_t   gnt;
  mid_t   head;
  logic   gnt_vld;
  logic   fwd;
  logic   accept;
  logic   fifo_full;
  logic   fifo_empty;
  logic   pop;

  always_comb begin
    gnt     = 1'b0;
    gnt_vld = 1'b0;
    if (state == HOLD) begin
      gnt     = owner;
      gnt_vld = owner ? m1_req_i : m0_req_i;
    end else if (m0_req_i && m1_req_i) begin
      gnt     = rr;
      gnt_vld = 1'b1;
    end else if (m0_req_i) begin
      gnt     = 1'b0;
      gnt_vld = 1'b1;
    end else if (m1_req_i) begin
      gnt     = 1'b1;
      gnt_vld = 1'b1;
    end
  end

  // Reset gates forwarding combinationally so masters cannot leak through while held.
  assign fwd    = gnt_vld & ~fifo_full & arst_n_i;
  assign accept = fwd & s_ack_i;

  always_comb begin
    s_req_o   = 1'b0;
    s_we_o    = 1'b0;
    s_addr_o  = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    if (fwd) begin
      s_req_o   = 1'b1;
      s_we_o    = gnt ? m1_we_i    : m0_we_i;
      s_addr_o  = gnt ? m1_addr_i  : m0_addr_i;
      s_be_o    = gnt ? m1_be_i    : m0_be_i;
      s_wdata_o = gnt ? m1_wdata_i : m0_wdata_i;
    end
  end

  assign m0_ack_o = accept & (gnt == 1'b0);
  assign m1_ack_o = accept & (gnt == 1'b1);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    case (state)
      IDLE: begin
        if (fwd && !s_ack_i) begin
          state_nxt = HOLD;
          owner_nxt = gnt;
        end
      end
      HOLD: begin
        if (accept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state <= IDLE;
      owner <= 1'b0;
      rr    <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (accept) rr <= ~gnt;
      if (s_resp_i && fifo_empty) err_o <= 1'b1;
    end
  end

  assign pop = s_resp_i & ~fifo_empty;

  mem_arb_tag_fifo #(
    .DEPTH(MAX_OUTST)
  ) u_tag_fifo (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .push_i    (accept & ~s_we_o),
    .push_id_i (gnt),
    .pop_i     (pop),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (head)
  );

  assign m0_resp_o  = pop & (head == 1'b0);
  assign m1_resp_o  = pop & (head == 1'b1);
  assign m0_rdata_o = m0_resp_o ? s_rdata_i : '0;
  assign m1_rdata_o = m1_resp_o ? s_rdata_i : '0;

endmodule

// File: doc/mem_arb2.md
MEM_ARB2 -- requirements
Module: mem_arb2

Interface
REQ-001 SHALL have parameter MAX_OUTST, default 4, meaning the maximum number of unanswered reads; legal values are powers of two >= 2.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port arst_n_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports m0_req_i / m1_req_i, input, 1, master request.
REQ-005 SHALL have ports m0_we_i / m1_we_i, input, 1, write enable; 0 means read.
REQ-006 SHALL have ports m0_addr_i / m1_addr_i, input, 32, byte address.
REQ-007 SHALL have ports m0_be_i / m1_be_i, input, 4, byte enables.
REQ-008 SHALL have ports m0_wdata_i / m1_wdata_i, input, 32, write data.
REQ-009 SHALL have ports m0_ack_o / m1_ack_o, output, 1, request accepted.
REQ-010 SHALL have ports m0_resp_o / m1_resp_o, output, 1, read data valid.
REQ-011 SHALL have ports m0_rdata_o / m1_rdata_o, output, 32, read data.
REQ-012 SHALL have ports s_req_o, s_we_o, s_addr_o[31:0], s_be_o[3:0] and s_wdata_o[31:0], outputs, carrying the forwarded request to the shared memory slave.
REQ-013 SHALL have ports s_ack_i, s_resp_i and s_rdata_i[31:0], inputs, carrying the slave's accept, read-valid and read-data.
REQ-014 SHALL have port err_o, output, 1, sticky flag for a response arriving with no read outstanding.

Function
REQ-015 SHALL implement FSM states IDLE and HOLD with an owner register (0/1).
- IDLE: a request from exactly one master grants that master.
- IDLE: requests from both masters grant the master pointed to by the round-robin pointer rr.
- The grant SHALL be combinational in the cycle the request is seen.
REQ-016 SHALL move from IDLE to HOLD when a granted request is not acked in that cycle; in HOLD, the grant SHALL stay on owner regardless of the other master.
REQ-017 SHALL return to IDLE from HOLD on s_req_o & s_ack_i.
REQ-018 SHALL drive s_req_o, s_we_o, s_addr_o, s_be_o and s_wdata_o from the granted master. With no grant, s_req_o=0 and the other slave outputs SHALL be 0.
REQ-019 SHALL drive mX_ack_o = s_ack_i & s_req_o & (grant==X); the non-granted master's ack SHALL be 0.
REQ-020 SHALL, on each accepted transaction, set rr to the master that was not served.
REQ-021 SHALL, on each accepted read, push the granted master id into a tag FIFO of depth MAX_OUTST; accepted writes SHALL push nothing.
REQ-022 SHALL, on s_resp_i, pop the FIFO head and assert resp_o for that master in the same cycle (zero latency).
- That master's rdata_o = s_rdata_i; the other master's rdata_o = 0.
REQ-023 SHALL force s_req_o=0 while the FIFO is full, even if a pop occurs in the same cycle; the current state and owner SHALL be retained.
REQ-024 SHALL allow a push and a pop in the same cycle when the FIFO is not full; the count is then unchanged.
REQ-025 SHALL, on s_resp_i with the FIFO empty, drop the response, assert no mX_resp_o, and set err_o; err_o SHALL clear only on reset.
REQ-026 SHALL handle FIFO pointer wrap-around modulo MAX_OUTST and hold a count of width log2(MAX_OUTST)+1.

Reset
REQ-027 SHALL, while arst_n_i=0, set state=IDLE, rr=0, FIFO count and pointers =0, and err_o=0.
REQ-028 SHALL hold all ack, resp and rdata outputs and all slave outputs at 0 during reset.
REQ-029 SHALL treat a reset mid-operation as discarding all outstanding tags; responses arriving after reset set err_o per REQ-025.

Structure
REQ-030 SHALL place in package mem_arb_pkg:
- the constants ADDR_W=32, DATA_W=32, BE_W=4;
- the master-id typedef;
- the FSM state enum.
REQ-031 SHALL implement the tag FIFO as sub-module mem_arb_tag_fifo, parameterized by depth, with push/pop/full/empty and a head id.

Verification
REQ-032 SHALL cover: m0 reads 0x100 alone, s_ack_i the same cycle, s_resp_i 2 cycles later with 0xDEADBEEF -> m0_ack_o 1 cycle, m0_resp_o 1 cycle with 0xDEADBEEF, m1 outputs 0.
REQ-033 SHALL cover: both masters request continuously after reset with the slave always acking -> grants alternate m0,m1,m0,m1.
REQ-034 SHALL cover: m1 granted with s_ack_i held low 3 cycles while m0 also requests -> grant stays m1 until ack; m0 is acked on the next cycle.
REQ-035 SHALL cover: 4 m0 reads acked with no responses (MAX_OUTST=4) -> s_req_o=0 on the 5th request; one s_resp_i -> s_req_o=1 the next cycle.
REQ-036 SHALL cover: interleaved reads m0,m1,m0 then 3 responses 0x1,0x2,0x3 -> m0 gets 0x1, m1 gets 0x2, m0 gets 0x3.
REQ-037 SHALL cover: arst_n_i pulsed low with 2 reads outstanding, then s_resp_i -> no mX_resp_o; err_o=1 and stays 1.
